dram_req_ctrl: RTL and testbench

DRAM_REQ_CTRL -- requirements
Module: dram_req_ctrl

---
 rtl/dram_pkg.sv | 19 +
 rtl/dram_rsp_fifo.sv | 51 +++++
 rtl/dram_req_ctrl.sv | 95 +++++++++
 tb/tb_dram_req_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared widths and response-entry type for the DRAM request controller.
package dram_pkg;

  localparam int ADDR_WIDTH     = 15;
  localparam int DATA_WIDTH     = 32;
  localparam int BE_WIDTH       = DATA_WIDTH / 8;
  localparam int RSP_FIFO_DEPTH = 3;
  localparam int RSP_CNT_W      = $clog2(RSP_FIFO_DEPTH + 1);

  typedef struct packed {
    logic                  err;
    logic [DATA_WIDTH-1:0] rdata;
  } rsp_entry_t;

  function automatic logic is_aligned(input logic [1:0] byte_lsb);
    return byte_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/dram_rsp_fifo.sv
// Small synchronous response FIFO with registered occupancy count.
module dram_rsp_fifo #(
  parameter int  DEPTH   = dram_pkg::RSP_FIFO_DEPTH,
  parameter type entry_t = dram_pkg::rsp_entry_t,
  parameter int  CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  output entry_t           head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t           storage [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        storage[wr_ptr] <= push_data;
        wr_ptr          <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = storage[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/dram_req_ctrl.sv
// Request/response front end for a single-port synchronous RAM with a
// one-cycle read latency; responses are returned in order through a small FIFO.
module dram_req_ctrl #(
  parameter int ADDR_WIDTH = dram_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = dram_pkg::DATA_WIDTH,
  parameter int BE_WIDTH   = dram_pkg::BE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [BE_WIDTH-1:0]   req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_wr_en,
  output logic [BE_WIDTH-1:0]   mem_wr_byte_en,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_rst
);

  import dram_pkg::*;

  typedef struct packed {
    logic                  err;
    logic [DATA_WIDTH-1:0] rdata;
  } entry_t;

  logic                 accept;
  logic                 aligned;
  logic                 inflight;
  logic                 inflight_err;
  logic                 inflight_we;
  entry_t               push_entry;
  entry_t               head;
  logic                 fifo_empty;
  logic [RSP_CNT_W-1:0] fifo_count;
  logic [RSP_CNT_W:0]   occupancy;

  // Reserve a FIFO slot at acceptance so the push one cycle later can never overflow.
  assign occupancy = {1'b0, fifo_count} + (RSP_CNT_W + 1)'(inflight);
  assign req_ready = rst && (occupancy < (RSP_CNT_W + 1)'(RSP_FIFO_DEPTH));
  assign accept    = req_valid && req_ready;
  assign aligned   = is_aligned(req_addr[1:0]);

  assign mem_addr       = req_addr[ADDR_WIDTH+1:2];
  assign mem_wr_data    = req_wdata;
  assign mem_wr_byte_en = req_be;
  assign mem_wr_en      = accept && req_we && aligned;
  assign mem_rst        = ~rst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      inflight     <= 1'b0;
      inflight_err <= 1'b0;
      inflight_we  <= 1'b0;
    end else begin
      inflight     <= accept;
      inflight_err <= !aligned;
      inflight_we  <= req_we;
    end
  end

  // RAM read data is only meaningful for the cycle after an aligned read.
  always_comb begin
    push_entry.err   = inflight_err;
    push_entry.rdata = (inflight_err || inflight_we) ? '0 : mem_rd_data;
  end

  dram_rsp_fifo #(
    .DEPTH   (RSP_FIFO_DEPTH),
    .entry_t (entry_t),
    .CNT_W   (RSP_CNT_W)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (push_entry),
    .pop       (rsp_valid && rsp_ready),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_rdata = rsp_valid ? head.rdata : '0;
  assign rsp_err   = rsp_valid && head.err;

endmodule

// File: tb/tb_dram_req_ctrl.sv
// Randomized and directed bench for dram_req_ctrl against an in-order
// response model with a shadow copy of RAM contents.
module tb_dram_req_ctrl;

  import dram_pkg::*;

  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int BW = BE_WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW+1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [BW-1:0] req_be = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_wr_en;
  logic [BW-1:0] mem_wr_byte_en;
  logic [DW-1:0] mem_rd_data = '0;
  logic          mem_rst;

  dram_req_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BE_WIDTH   (BW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_be         (req_be),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .mem_addr       (mem_addr),
    .mem_wr_data    (mem_wr_data),
    .mem_wr_en      (mem_wr_en),
    .mem_wr_byte_en (mem_wr_byte_en),
    .mem_rd_data    (mem_rd_data),
    .mem_rst        (mem_rst)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM, read-first, one-cycle read latency.
  logic [DW-1:0] ram [2**AW];
  always @(posedge clk) begin
    logic [DW-1:0] word;
    word = ram[mem_addr];
    mem_rd_data <= word;
    if (mem_wr_en) begin
      for (int b = 0; b < BW; b++)
        if (mem_wr_byte_en[b]) word[8*b +: 8] = mem_wr_data[8*b +: 8];
      ram[mem_addr] <= word;
    end
  end

  typedef struct {
    logic          err;
    logic [DW-1:0] rdata;
    int            due;
  } exp_t;

  typedef struct {
    logic          err;
    logic [DW-1:0] rdata;
    int            cyc;
  } obs_t;

  exp_t          exp_q[$];
  obs_t          obs_q[$];
  int            acc_q[$];
  logic [DW-1:0] shadow [2**AW];
  int            cyc = 0;
  int            vectors = 0;
  int            miscompares = 0;
  logic          last_acc = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Called at a falling edge after inputs are driven; checks, then advances one cycle.
  task automatic cycle_step();
    logic exp_ready, exp_valid, exp_wen, acc, pop;
    exp_t e;
    logic [DW-1:0] w;
    #1;
    exp_ready = rst && (exp_q.size() < RSP_FIFO_DEPTH);
    exp_valid = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
    acc       = req_valid && exp_ready;
    exp_wen   = acc && req_we && (req_addr[1:0] == 2'b00);
    chk("req_ready", req_ready, exp_ready);
    chk("rsp_valid", rsp_valid, exp_valid);
    if (exp_valid) begin
      chk("rsp_err", rsp_err, exp_q[0].err);
      chk("rsp_rdata", rsp_rdata, exp_q[0].rdata);
    end
    chk("mem_wr_en", mem_wr_en, exp_wen);
    chk("mem_addr", mem_addr, req_addr[AW+1:2]);
    chk("mem_wr_data", mem_wr_data, req_wdata);
    chk("mem_wr_byte_en", mem_wr_byte_en, req_be);
    chk("mem_rst", mem_rst, !rst);
    pop = exp_valid && rsp_ready && rst;
    if (pop) obs_q.push_back('{err: rsp_err, rdata: rsp_rdata, cyc: cyc});
    last_acc = acc;
    @(posedge clk);
    if (!rst) begin
      exp_q.delete();
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) begin
        if (req_addr[1:0] != 2'b00) begin
          e = '{err: 1'b1, rdata: '0, due: cyc + 2};
        end else if (req_we) begin
          w = shadow[req_addr[AW+1:2]];
          for (int b = 0; b < BW; b++)
            if (req_be[b]) w[8*b +: 8] = req_wdata[8*b +: 8];
          shadow[req_addr[AW+1:2]] = w;
          e = '{err: 1'b0, rdata: '0, due: cyc + 2};
        end else begin
          e = '{err: 1'b0, rdata: shadow[req_addr[AW+1:2]], due: cyc + 2};
        end
        exp_q.push_back(e);
        acc_q.push_back(cyc);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic we, input logic [AW+1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] be, input logic rr);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    rsp_ready = rr;
    cycle_step();
  endtask

  task automatic issue(input logic we, input logic [AW+1:0] a, input logic [DW-1:0] d,
                       input logic [BW-1:0] be, input logic rr);
    int tries = 0;
    do begin
      drive(1'b1, we, a, d, be, rr);
      tries++;
    end while (!last_acc && tries < 50);
    req_valid = 1'b0;
    if (!last_acc) begin
      miscompares++;
      $display("FAIL issue_timeout: request at 0x%0h never accepted within 50 cycles", a);
    end
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, '0, rr);
  endtask

  task automatic clear_logs();
    obs_q.delete();
    acc_q.delete();
  endtask

  initial begin
    int n, n_stalled, k;
    @(negedge clk);

    // Reset held with a write request pending: nothing may leak out.
    rst = 1'b0;
    drive(1'b1, 1'b1, '0, 32'h1234_5678, 4'hF, 1'b1);
    drive(1'b1, 1'b1, '0, 32'h1234_5678, 4'hF, 1'b1);
    #1;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, '0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_mem_wr_en", mem_wr_en, 1'b0);
    chk("rst_mem_rst", mem_rst, 1'b1);
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("post_rst_ready", req_ready, 1'b1);
    @(negedge clk);

    for (int wa = 0; wa < 64; wa++) issue(1'b1, (AW+2)'(wa * 4), $urandom, 4'hF, 1'b1);
    idle(4, 1'b1);

    // Write then read back the same word.
    clear_logs();
    issue(1'b1, 'h10, 32'hDEAD_BEEF, 4'hF, 1'b1);
    issue(1'b0, 'h10, '0, '0, 1'b1);
    idle(4, 1'b1);
    chk("t_wr_rd_count", obs_q.size(), 2);
    if (obs_q.size() >= 2) begin
      chk("t_wr_rsp_err", obs_q[0].err, 1'b0);
      chk("t_wr_rsp_data", obs_q[0].rdata, 32'h0);
      chk("t_rd_data", obs_q[1].rdata, 32'hDEAD_BEEF);
      chk("t_rd_latency", obs_q[1].cyc - acc_q[1], 2);
    end

    // Byte-enable merge.
    clear_logs();
    issue(1'b1, 'h20, 32'h1122_3344, 4'hF, 1'b1);
    issue(1'b1, 'h20, 32'hAABB_CCDD, 4'h5, 1'b1);
    issue(1'b1, 'h20, 32'hFFFF_FFFF, 4'h0, 1'b1);
    issue(1'b0, 'h20, '0, '0, 1'b1);
    idle(4, 1'b1);
    chk("t_be_count", obs_q.size(), 4);
    if (obs_q.size() >= 4) chk("t_be_merge", obs_q[3].rdata, 32'h11BB_33DD);

    // Misaligned read and write, then confirm the aligned word is untouched.
    clear_logs();
    issue(1'b0, 'h06, '0, '0, 1'b1);
    issue(1'b1, 'h12, 32'hCAFE_F00D, 4'hF, 1'b1);
    issue(1'b0, 'h10, '0, '0, 1'b1);
    idle(4, 1'b1);
    chk("t_mis_count", obs_q.size(), 3);
    if (obs_q.size() >= 3) begin
      chk("t_mis_rd_err", obs_q[0].err, 1'b1);
      chk("t_mis_rd_data", obs_q[0].rdata, 32'h0);
      chk("t_mis_wr_err", obs_q[1].err, 1'b1);
      chk("t_mis_untouched", obs_q[2].rdata, 32'hDEAD_BEEF);
    end

    // Back-pressure: 8 reads with the response side stalled for 8 cycles.
    clear_logs();
    n = 0;
    n_stalled = 0;
    k = 0;
    while (n < 8 && k < 100) begin
      drive(1'b1, 1'b0, (AW+2)'('h40 + 4 * n), '0, '0, k >= 8);
      if (last_acc) n++;
      if (k == 7) n_stalled = n;
      k++;
    end
    idle(8, 1'b1);
    chk("t_bp_stalled_accepts", n_stalled, 3);
    chk("t_bp_all_accepted", n, 8);
    chk("t_bp_responses", obs_q.size(), 8);

    // Streaming reads at full rate.
    clear_logs();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, (AW+2)'(4 * ($urandom % 64)), '0, '0, 1'b1);
      if (last_acc) n++;
    end
    idle(4, 1'b1);
    chk("t_stream_accepts", n, 20);
    chk("t_stream_responses", obs_q.size(), 20);
    if (obs_q.size() == 20) chk("t_stream_rate", obs_q[19].cyc - obs_q[0].cyc, 19);

    // Reset with two FIFO entries and one read in flight.
    clear_logs();
    issue(1'b0, 'h44, '0, '0, 1'b0);
    issue(1'b0, 'h48, '0, '0, 1'b0);
    issue(1'b0, 'h4C, '0, '0, 1'b0);
    rst = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
    #1;
    chk("t_rst_flush_valid", rsp_valid, 1'b0);
    chk("t_rst_flush_ready", req_ready, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    clear_logs();
    idle(6, 1'b1);
    chk("t_rst_no_stale", obs_q.size(), 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic [AW+1:0] a;
      a = (AW+2)'(4 * ($urandom % 64));
      if ($urandom % 4 == 0) a[1:0] = 2'($urandom);
      if ($urandom % 400 == 0) rst = 1'b0;
      else rst = 1'b1;
      drive(($urandom % 4) != 0, 1'($urandom), a, $urandom, 4'($urandom),
            ($urandom % 10) < 7);
    end
    rst = 1'b1;
    idle(8, 1'b1);
    chk("final_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
